// File: rtl/memory_access_pkg.sv
// Shared types for the byte-serial memory access unit.
// FSM states, transfer direction and word geometry.
package memory_access;

  typedef enum logic [1:0] {
    Idle,
    Transfer,
    Done
  } memory_access_state_t;

  typedef enum logic {
    Read,
    Write
  } memory_direction_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/memory_access_unit.sv
// Splits a 32-bit load/store into four byte transfers on an 8-bit bus.
// Stalls the core while busy and assembles load data little-endian.
module memory_access_unit
  import memory_access::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     request_valid,
  input  logic                     memory_write,
  input  logic                     memory_read,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     bus_request,
  output logic                     bus_write,
  output logic [ADDRESS_WIDTH-1:0] bus_address,
  output logic [BYTE_WIDTH-1:0]    bus_write_data,
  input  logic                     bus_acknowledge,
  input  logic [BYTE_WIDTH-1:0]    bus_read_data
);

  localparam int IW = $clog2(BYTES_PER_WORD);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_WORD - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  memory_access_state_t     state_q, state_d;
  memory_direction_t        dir_q, dir_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     error_q, error_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= Idle;
      dir_q   <= Read;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    error_d = error_q;
    unique case (state_q)
      Idle: begin
        if (request_valid) begin
          addr_d  = address;
          wdata_d = write_data;
          error_d = 1'b0;
          idx_d   = '0;
          tmo_d   = '0;
          // write wins when both direction bits are set
          if (memory_write) begin
            dir_d   = Write;
            state_d = Transfer;
          end else if (memory_read) begin
            dir_d   = Read;
            state_d = Transfer;
          end else begin
            state_d = Done;
          end
        end
      end
      Transfer: begin
        if (bus_acknowledge) begin
          if (dir_q == Read)
            rdata_d[int'(idx_q)*BYTE_WIDTH +: BYTE_WIDTH] = bus_read_data;
          tmo_d = '0;
          if (idx_q == LAST_IDX) state_d = Done;
          else idx_d = idx_q + IW'(1);
        end else if (tmo_q == TMO_LAST) begin
          // abandon remaining bytes; written bytes stay written
          state_d = Done;
          error_d = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      Done: begin
        state_d = Idle;
        idx_d   = '0;
      end
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    busy           = (state_q != Idle);
    done           = (state_q == Done);
    error          = error_q;
    read_data      = rdata_q;
    bus_request    = (state_q == Transfer);
    bus_write      = 1'b0;
    bus_address    = '0;
    bus_write_data = '0;
    if (state_q == Transfer) begin
      bus_write      = (dir_q == Write);
      bus_address    = addr_q + ADDRESS_WIDTH'(idx_q);
      bus_write_data = wdata_q[int'(idx_q)*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: stores, loads, wrap,
// timeout, non-memory requests and mid-transfer reset.
module tb_memory_access_unit;

  logic        clock;
  logic        reset;
  logic        request_valid;
  logic        memory_write;
  logic        memory_read;
  logic [15:0] address;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] read_data;
  logic        bus_request;
  logic        bus_write;
  logic [15:0] bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_acknowledge;
  logic [7:0]  bus_read_data;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  memory_access_unit dut (
    .clock           (clock),
    .reset           (reset),
    .request_valid   (request_valid),
    .memory_write    (memory_write),
    .memory_read     (memory_read),
    .address         (address),
    .write_data      (write_data),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .read_data       (read_data),
    .bus_request     (bus_request),
    .bus_write       (bus_write),
    .bus_address     (bus_address),
    .bus_write_data  (bus_write_data),
    .bus_acknowledge (bus_acknowledge),
    .bus_read_data   (bus_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic issue(input logic w, input logic r,
                       input logic [15:0] a, input logic [31:0] d);
    request_valid = 1'b1;
    memory_write  = w;
    memory_read   = r;
    address       = a;
    write_data    = d;
    step();
    request_valid = 1'b0;
    memory_write  = 1'b0;
    memory_read   = 1'b0;
  endtask

  logic [31:0] wd;
  logic [15:0] exp_addr [4];
  int          d0;
  int          dly;

  initial begin
    reset           = 1'b1;
    request_valid   = 1'b0;
    memory_write    = 1'b0;
    memory_read     = 1'b0;
    address         = '0;
    write_data      = '0;
    bus_acknowledge = 1'b0;
    bus_read_data   = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_req", 32'(bus_request), 0);
    chk("rst_bwr", 32'(bus_write), 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_baddr", 32'(bus_address), 0);
    chk("rst_bwd", 32'(bus_write_data), 0);
    reset = 1'b0;
    step();

    // store 0xDEADBEEF to 0x0100, ack every cycle
    wd = 32'hDEADBEEF;
    bus_acknowledge = 1'b1;
    issue(1'b1, 1'b0, 16'h0100, wd);
    for (int k = 0; k < 4; k++) begin
      chk("st_busy", 32'(busy), 1);
      chk("st_req", 32'(bus_request), 1);
      chk("st_bwr", 32'(bus_write), 1);
      chk("st_addr", 32'(bus_address), 32'h0100 + k);
      chk("st_byte", 32'(bus_write_data), (wd >> (8*k)) & 32'hFF);
      step();
    end
    bus_acknowledge = 1'b0;
    chk("st_done", 32'(done), 1);
    chk("st_busy5", 32'(busy), 1);
    chk("st_req5", 32'(bus_request), 0);
    chk("st_err", 32'(error), 0);
    step();
    chk("st_idle_done", 32'(done), 0);
    chk("st_idle_busy", 32'(busy), 0);

    // load from 0x0200 with random ack delays
    d0 = done_cnt;
    issue(1'b0, 1'b1, 16'h0200, 32'h0);
    for (int k = 0; k < 4; k++) begin
      dly = $urandom_range(0, 3);
      for (int j = 0; j < dly; j++) begin
        chk("ld_wait_req", 32'(bus_request), 1);
        step();
      end
      chk("ld_addr", 32'(bus_address), 32'h0200 + k);
      chk("ld_bwr", 32'(bus_write), 0);
      bus_acknowledge = 1'b1;
      bus_read_data   = 8'(8'h11 * (k + 1));
      step();
      bus_acknowledge = 1'b0;
    end
    chk("ld_done", 32'(done), 1);
    chk("ld_rdata", read_data, 32'h44332211);
    step();
    chk("ld_done_once", 32'(done_cnt - d0), 1);
    chk("ld_hold", read_data, 32'h44332211);

    // store to 0xFFFE wraps
    exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    bus_acknowledge = 1'b1;
    issue(1'b1, 1'b0, 16'hFFFE, 32'h11223344);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_addr", 32'(bus_address), 32'(exp_addr[k]));
      step();
    end
    bus_acknowledge = 1'b0;
    chk("wrap_done", 32'(done), 1);
    step();

    // load with byte 2 never acknowledged
    issue(1'b0, 1'b1, 16'h0300, 32'h0);
    for (int k = 0; k < 2; k++) begin
      bus_acknowledge = 1'b1;
      bus_read_data   = (k == 0) ? 8'hAA : 8'hBB;
      step();
    end
    bus_acknowledge = 1'b0;
    for (int i = 0; i < 254; i++) step();
    chk("tmo_req_last", 32'(bus_request), 1);
    chk("tmo_addr", 32'(bus_address), 32'h0302);
    step();
    chk("tmo_req_drop", 32'(bus_request), 0);
    chk("tmo_done", 32'(done), 1);
    chk("tmo_err", 32'(error), 1);
    chk("tmo_rdata", read_data, 32'h4433BBAA);
    step();
    chk("tmo_err_sticky", 32'(error), 1);
    chk("tmo_idle", 32'(busy), 0);

    // non-memory request: done after one cycle, clears error
    issue(1'b0, 1'b0, 16'h0042, 32'h0);
    chk("nm_done", 32'(done), 1);
    chk("nm_req", 32'(bus_request), 0);
    chk("nm_err_clr", 32'(error), 0);
    step();
    chk("nm_idle", 32'(busy), 0);

    // both direction bits set: write wins
    bus_acknowledge = 1'b1;
    issue(1'b1, 1'b1, 16'h0010, 32'hCAFEF00D);
    chk("both_bwr", 32'(bus_write), 1);
    chk("both_byte0", 32'(bus_write_data), 32'h0D);
    for (int k = 0; k < 4; k++) step();
    bus_acknowledge = 1'b0;
    chk("both_done", 32'(done), 1);
    chk("both_rdata", read_data, 32'h4433BBAA);
    step();

    // reset during byte 1
    issue(1'b0, 1'b1, 16'h0400, 32'h0);
    bus_acknowledge = 1'b1;
    bus_read_data   = 8'h55;
    step();
    bus_acknowledge = 1'b0;
    chk("mr_pre_addr", 32'(bus_address), 32'h0401);
    reset = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_req", 32'(bus_request), 0);
    chk("mr_baddr", 32'(bus_address), 0);
    chk("mr_rdata", read_data, 0);
    step();
    reset = 1'b0;
    step();
    bus_acknowledge = 1'b1;
    issue(1'b0, 1'b1, 16'h0500, 32'h0);
    for (int k = 0; k < 4; k++) begin
      bus_read_data = 8'(k + 1);
      step();
    end
    bus_acknowledge = 1'b0;
    chk("post_done", 32'(done), 1);
    chk("post_rdata", read_data, 32'h04030201);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
